timer_sched: RTL
================

# timer_sched

Multi-channel timer scheduler built around an internal base-tick prescaler. It holds NCH independently programmable channels that count base ticks in one-shot or periodic mode. Expiries are queued as per-channel pending flags and handed out one at a time on a valid/ready event port under round-robin arbitration. It sits between the slow-clock generation logic and any block needing periodic or delayed service, and replaces multiple standalone dividers.

## Interface
- DIV, 10000 — base tick period in clk cycles (≥2)
- NCH, 4 — channel count; power of two, 2..8
- WIDTH, 16 — channel period/counter width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept; transfer when cfg_valid & cfg_ready
- cfg_ch  in  clog2(NCH)  target channel
- cfg_op  in  2  00 stop, 01 start one-shot, 10 start periodic, 11 clear pending
- cfg_period  in  WIDTH  period in base ticks (used by ops 01/10)
- evt_valid  out  1  expiry event available
- evt_ch  out  clog2(NCH)  channel of presented event
- evt_ready  in  1  consumer accepts event
- active  out  NCH  per-channel running flag
- tick  out  1  one-cycle base tick pulse
- overrun  out  NCH  sticky overrun flags (only with TIMER_SCHED_OVERRUN_EN)

## Operation
- Prescaler: cnt 0..DIV-1, wraps to 0; tick=1 in the cycle cnt==DIV-1. Width clog2(DIV).
- cfg_ready = ~tick; config is never applied in a tick cycle.
- Op 01/10 with cfg_period≠0: active=1, mode set, reload=count=cfg_period, pending cleared.
- Op 01/10 with cfg_period==0: treated as op 00.
- Op 00: active=0, count=0, pending cleared. An event already in the evt register is not withdrawn.
- Op 11: pending cleared. Also clears overrun[ch] when the macro is enabled.
- On tick, for each active channel: if count==1, the channel expires and pending is set. Periodic mode: count=reload. One-shot mode: active=0, count=0. Otherwise count decrements.
- First expiry comes exactly cfg_period ticks after acceptance.
- Event register: loads when empty (evt_valid=0) or when evt_valid & evt_ready.
  - Selects the first pending channel, searching upward from last_grant+1 modulo NCH.
  - Clears that channel's pending bit in the same cycle and updates last_grant.
  - If no channel is pending, evt_valid drops.
- Expiry and arbiter clear of the same channel in the same cycle: pending stays 1 (expiry wins).

## Timing
- Reset values: cnt=0, tick=0, all channels inactive, count=reload=0, pending=0, evt_valid=0, evt_ch=0, last_grant=NCH-1, active=0, overrun=0. cfg_ready is 1 one cycle after reset release.
- First tick occurs in the DIV-th cycle after reset release, then every DIV cycles.
- Expiry latency: pending sets at the edge ending the tick cycle. evt_valid is high at the earliest one cycle later.
- Back-to-back events: with evt_ready held high, one event per cycle.
- evt_valid/evt_ch stay stable while evt_valid & ~evt_ready.
- Reset mid-operation clears everything immediately, including the held event.

## Configuration
- TIMER_SCHED_OVERRUN_EN defined:
  - overrun port exists.
  - overrun[i] sets when channel i expires while pending[i] is already 1 and not being cleared by the arbiter that cycle.
  - Remains set until op 11 on channel i or reset.
- Undefined: overrun port and its logic are absent. A repeat expiry on an already-pending channel is silently merged.

## Test plan
- DIV=4, ch0 op10 period 3, evt_ready=1 → tick every 4 cycles; evt_valid with evt_ch=0 every 12 cycles, starting 1 cycle after the 3rd tick.
- ch2 op01 period 2 → exactly one event evt_ch=2; active[2] falls on the 2nd tick.
- ch0..ch3 all op10 period 1, evt_ready=1 → events in order 0,1,2,3, one per cycle after each tick. Repeat with evt_ready held low 5 cycles → evt_ch=0 holds stable.
- cfg_valid held in a tick cycle → cfg_ready=0; accepted the next cycle. op10 period 0 → active stays 0.
- Macro on: ch1 period 1, evt_ready=0 for 3 ticks → overrun[1]=1; op11 ch1 → overrun[1]=0, pending cleared.
- Assert rst while evt_valid=1 and channels running → all outputs return to reset values; no event after release without new config.

Source files
------------

// File: rtl/timer_sched_if.sv
// Config request and expiry-event handshake bundle for timer_sched.
// The master side issues channel configs and consumes expiry events.
interface timer_sched_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
) ();
  localparam int CW = $clog2(NCH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CW-1:0]    cfg_ch;
  logic [1:0]       cfg_op;
  logic [WIDTH-1:0] cfg_period;
  logic             evt_valid;
  logic [CW-1:0]    evt_ch;
  logic             evt_ready;

  modport master (
    output cfg_valid, cfg_ch, cfg_op, cfg_period, evt_ready,
    input  cfg_ready, evt_valid, evt_ch
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_op, cfg_period, evt_ready,
    output cfg_ready, evt_valid, evt_ch
  );
endinterface

// File: rtl/timer_sched.sv
// Base-tick prescaler feeding NCH one-shot/periodic channels; expiries are handed out round-robin.
// Define TIMER_SCHED_OVERRUN_EN to add sticky per-channel overrun flags and the overrun port.
module timer_sched #(
  parameter int DIV   = 10000,
  parameter int NCH   = 4,
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  timer_sched_if.slave   bus,
  output logic [NCH-1:0] active,
  output logic           tick
`ifdef TIMER_SCHED_OVERRUN_EN
  ,
  output logic [NCH-1:0] overrun
`endif
);
  localparam int CW = $clog2(NCH);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);
  localparam logic [1:0] OP_ONESHOT  = 2'b01;
  localparam logic [1:0] OP_PERIODIC = 2'b10;
  localparam logic [1:0] OP_CLEAR    = 2'b11;

  logic [PW-1:0]    cnt;
  logic [WIDTH-1:0] count  [NCH];
  logic [WIDTH-1:0] reload [NCH];
  logic [NCH-1:0]   periodic;
  logic [NCH-1:0]   pending;
  logic             evt_valid_q;
  logic [CW-1:0]    evt_ch_q;
  logic [CW-1:0]    last_grant;

  logic             cfg_fire;
  logic             cfg_start;
  logic             evt_load;
  logic             gnt_found;
  logic [CW-1:0]    gnt_idx;
  logic [CW-1:0]    gnt_probe;
  logic [NCH-1:0]   expire;
  logic [NCH-1:0]   cfg_hit;
  logic [NCH-1:0]   gnt_clr;

  assign tick          = (cnt == CNT_LAST);
  assign bus.cfg_ready = ~tick;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_ch    = evt_ch_q;
  assign cfg_fire      = bus.cfg_valid & ~tick;
  assign cfg_start     = ((bus.cfg_op == OP_ONESHOT) || (bus.cfg_op == OP_PERIODIC))
                         && (bus.cfg_period != '0);
  assign evt_load      = ~evt_valid_q | bus.evt_ready;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      expire[i]  = tick & active[i] & (count[i] == WIDTH'(1));
      cfg_hit[i] = cfg_fire & (bus.cfg_ch == CW'(i));
    end
  end

  // Round-robin search starts just past the last granted channel.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_grant;
    gnt_probe = last_grant;
    for (int k = 1; k <= NCH; k++) begin
      gnt_probe = last_grant + CW'(k);
      if (!gnt_found && pending[gnt_probe]) begin
        gnt_found = 1'b1;
        gnt_idx   = gnt_probe;
      end
    end
    gnt_clr = (evt_load && gnt_found) ? (NCH'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      active      <= '0;
      periodic    <= '0;
      pending     <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      last_grant  <= CW'(NCH - 1);
      for (int i = 0; i < NCH; i++) begin
        count[i]  <= '0;
        reload[i] <= '0;
      end
`ifdef TIMER_SCHED_OVERRUN_EN
      overrun     <= '0;
`endif
    end else begin
      cnt <= tick ? '0 : cnt + PW'(1);

      for (int i = 0; i < NCH; i++) begin
        if (cfg_hit[i]) begin
          if (cfg_start) begin
            active[i]   <= 1'b1;
            periodic[i] <= (bus.cfg_op == OP_PERIODIC);
            reload[i]   <= bus.cfg_period;
            count[i]    <= bus.cfg_period;
          end else if (bus.cfg_op != OP_CLEAR) begin
            active[i] <= 1'b0;
            count[i]  <= '0;
          end
        end else if (expire[i]) begin
          if (periodic[i]) begin
            count[i] <= reload[i];
          end else begin
            active[i] <= 1'b0;
            count[i]  <= '0;
          end
        end else if (tick && active[i]) begin
          count[i] <= count[i] - WIDTH'(1);
        end

        // A fresh expiry beats an arbiter clear in the same cycle.
        pending[i] <= expire[i] | (pending[i] & ~gnt_clr[i] & ~cfg_hit[i]);

`ifdef TIMER_SCHED_OVERRUN_EN
        if (cfg_hit[i] && (bus.cfg_op == OP_CLEAR))
          overrun[i] <= 1'b0;
        else if (expire[i] && pending[i] && !gnt_clr[i])
          overrun[i] <= 1'b1;
`endif
      end

      if (evt_load) begin
        evt_valid_q <= gnt_found;
        if (gnt_found) begin
          evt_ch_q   <= gnt_idx;
          last_grant <= gnt_idx;
        end
      end
    end
  end
endmodule
